z3_dma_cycle: RTL and testbench

Z3_DMA_CYCLE -- requirements
Module: z3_dma_cycle

---
 rtl/z3_dma_cycle.sv | 229 ++++++++++++++++++++++
 tb/tb_z3_dma_cycle.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/z3_dma_cycle.sv
// Zorro III DMA bus-cycle sequencer for a SCSI-chip bus master.
// Converts one SCSI-chip master cycle (SAS_n) into one Zorro III cycle:
// address phase, full-cycle strobe, lane-decoded data strobes, and a
// normal (STA_n) or error (STEA_n) acknowledge back to the SCSI chip.
//
// Ports:
//   clk            sole clock, rising edge
//   IORST_n        synchronous active-low reset
//   mybus          bus ownership granted by the DMA arbiter
//   SAS_n          SCSI-chip address strobe (cycle request)
//   SRW            SCSI-chip direction, 1 = read
//   SSIZ[1:0]      transfer size: 00 long, 01 byte, 10 word, 11 line (as long)
//   SA[1:0]        SCSI-chip address bits A1..A0
//   DTACK_n        Zorro III slave acknowledge (pre-synchronised)
//   BERR_n         Zorro III bus error (pre-synchronised)
//   FCS_n          Zorro III full-cycle strobe
//   DS_n[3:0]      data strobes, DS_n[3] = D31..24
//   READ           Zorro III direction
//   ADOE           address output enable
//   DOE            data output enable
//   DLATCH         one-cycle read-data capture pulse
//   STA_n          transfer acknowledge to the SCSI chip
//   STEA_n         transfer error acknowledge to the SCSI chip
module z3_dma_cycle (
  input  logic       clk,
  input  logic       IORST_n,
  input  logic       mybus,
  input  logic       SAS_n,
  input  logic       SRW,
  input  logic [1:0] SSIZ,
  input  logic [1:0] SA,
  input  logic       DTACK_n,
  input  logic       BERR_n,
  output logic       FCS_n,
  output logic [3:0] DS_n,
  output logic       READ,
  output logic       ADOE,
  output logic       DOE,
  output logic       DLATCH,
  output logic       STA_n,
  output logic       STEA_n
);

  localparam int unsigned TMO_W = 8;
  // The count at which the next WAIT increment reaches 255 and the cycle is abandoned.
  localparam logic [TMO_W-1:0] TMO_EXIT = TMO_W'(254);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(255);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STROBE,
    ST_WAIT,
    ST_TERM,
    ST_RELEASE
  } state_t;

  state_t           state, state_nxt;
  logic             term_err, term_err_nxt;
  logic [3:0]       lane_q, lane_nxt;
  logic [TMO_W-1:0] tmo_cnt;

  logic       fcs_n_nxt;
  logic [3:0] ds_n_nxt;
  logic       read_nxt;
  logic       adoe_nxt;
  logic       doe_nxt;
  logic       dlatch_nxt;
  logic       sta_n_nxt;
  logic       stea_n_nxt;

  // Active-low byte-lane strobes for the requested size and address.
  function automatic logic [3:0] lane_decode(input logic [1:0] siz, input logic [1:0] a);
    logic [3:0] lanes;
    lanes = 4'b0000;
    unique case (siz)
      2'b01: begin
        unique case (a)
          2'b00:   lanes = 4'b0111;
          2'b01:   lanes = 4'b1011;
          2'b10:   lanes = 4'b1101;
          default: lanes = 4'b1110;
        endcase
      end
      2'b10:   lanes = a[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

  // State, termination type, latched lanes and all outputs.
  always_ff @(posedge clk) begin
    if (!IORST_n) begin
      state    <= ST_IDLE;
      term_err <= 1'b0;
      lane_q   <= 4'b1111;
      FCS_n    <= 1'b1;
      DS_n     <= 4'b1111;
      READ     <= 1'b0;
      ADOE     <= 1'b0;
      DOE      <= 1'b0;
      DLATCH   <= 1'b0;
      STA_n    <= 1'b1;
      STEA_n   <= 1'b1;
    end else begin
      state    <= state_nxt;
      term_err <= term_err_nxt;
      lane_q   <= lane_nxt;
      FCS_n    <= fcs_n_nxt;
      DS_n     <= ds_n_nxt;
      READ     <= read_nxt;
      ADOE     <= adoe_nxt;
      DOE      <= doe_nxt;
      DLATCH   <= dlatch_nxt;
      STA_n    <= sta_n_nxt;
      STEA_n   <= stea_n_nxt;
    end
  end

  // Slave-response timeout: counts WAIT cycles only, holds at its ceiling.
  always_ff @(posedge clk) begin
    if (!IORST_n || state != ST_WAIT) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Next state, then outputs decoded from the next state so they line up with it.
  always_comb begin
    state_nxt    = state;
    term_err_nxt = term_err;
    lane_nxt     = lane_q;

    unique case (state)
      ST_IDLE: begin
        if (mybus && !SAS_n) begin
          state_nxt = ST_ADDR;
          lane_nxt  = lane_decode(SSIZ, SA);
        end
      end
      ST_ADDR, ST_STROBE: begin
        // Losing the bus mid-cycle still acknowledges the SCSI chip, with an error.
        if (!mybus) begin
          state_nxt    = ST_TERM;
          term_err_nxt = 1'b1;
        end else begin
          state_nxt = (state == ST_ADDR) ? ST_STROBE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!mybus || !BERR_n) begin
          state_nxt    = ST_TERM;
          term_err_nxt = 1'b1;
        end else if (!DTACK_n) begin
          state_nxt    = ST_TERM;
          term_err_nxt = 1'b0;
        end else if (tmo_cnt == TMO_EXIT) begin
          state_nxt    = ST_TERM;
          term_err_nxt = 1'b1;
        end
      end
      ST_TERM: begin
        state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Wait for both sides to let go before another cycle may start.
        if (SAS_n && DTACK_n) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    fcs_n_nxt  = 1'b1;
    ds_n_nxt   = DS_n;
    read_nxt   = READ;
    adoe_nxt   = 1'b0;
    doe_nxt    = DOE;
    dlatch_nxt = 1'b0;
    sta_n_nxt  = 1'b1;
    stea_n_nxt = 1'b1;

    unique case (state_nxt)
      ST_IDLE: begin
        ds_n_nxt = 4'b1111;
        read_nxt = 1'b0;
        doe_nxt  = 1'b0;
      end
      ST_ADDR: begin
        // ADDR is only ever entered from IDLE, so this latches direction once.
        adoe_nxt = 1'b1;
        read_nxt = SRW;
        ds_n_nxt = 4'b1111;
        doe_nxt  = 1'b0;
      end
      ST_STROBE: begin
        adoe_nxt  = 1'b1;
        fcs_n_nxt = 1'b0;
      end
      ST_WAIT: begin
        adoe_nxt  = 1'b1;
        fcs_n_nxt = 1'b0;
        ds_n_nxt  = lane_q;
        doe_nxt   = 1'b1;
      end
      ST_TERM: begin
        // DS_n/DOE hold, so an abort before WAIT never pulses the data strobes.
        adoe_nxt   = 1'b1;
        fcs_n_nxt  = 1'b0;
        sta_n_nxt  = term_err_nxt;
        stea_n_nxt = !term_err_nxt;
        dlatch_nxt = !term_err_nxt && READ;
      end
      ST_RELEASE: begin
        adoe_nxt = 1'b1;
        ds_n_nxt = 4'b1111;
        doe_nxt  = 1'b0;
      end
      default: begin
        ds_n_nxt = 4'b1111;
        doe_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_z3_dma_cycle.sv
// Scoreboard bench for z3_dma_cycle: each driven cycle pushes its expected
// acknowledge; a monitor pops and compares when STA_n/STEA_n asserts.
module tb_z3_dma_cycle;

  logic       clk = 1'b0;
  logic       IORST_n;
  logic       mybus;
  logic       SAS_n;
  logic       SRW;
  logic [1:0] SSIZ;
  logic [1:0] SA;
  logic       DTACK_n;
  logic       BERR_n;
  logic       FCS_n;
  logic [3:0] DS_n;
  logic       READ;
  logic       ADOE;
  logic       DOE;
  logic       DLATCH;
  logic       STA_n;
  logic       STEA_n;

  always #5 clk = ~clk;

  z3_dma_cycle dut (
    .clk     (clk),
    .IORST_n (IORST_n),
    .mybus   (mybus),
    .SAS_n   (SAS_n),
    .SRW     (SRW),
    .SSIZ    (SSIZ),
    .SA      (SA),
    .DTACK_n (DTACK_n),
    .BERR_n  (BERR_n),
    .FCS_n   (FCS_n),
    .DS_n    (DS_n),
    .READ    (READ),
    .ADOE    (ADOE),
    .DOE     (DOE),
    .DLATCH  (DLATCH),
    .STA_n   (STA_n),
    .STEA_n  (STEA_n)
  );

  typedef struct {
    logic       sta_n;
    logic       stea_n;
    logic       dlatch;
    logic [3:0] ds_n;
    logic       read;
    int         waits;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   waits_seen = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [3:0] exp_lanes(input logic [1:0] siz, input logic [1:0] a);
    logic [3:0] r;
    if (siz == 2'b01) begin
      if (a == 2'b00)      r = 4'b0111;
      else if (a == 2'b01) r = 4'b1011;
      else if (a == 2'b10) r = 4'b1101;
      else                 r = 4'b1110;
    end else if (siz == 2'b10) begin
      r = (a >= 2'b10) ? 4'b1100 : 4'b0011;
    end else begin
      r = 4'b0000;
    end
    return r;
  endfunction

  task automatic check_reset(input string pfx);
    check({pfx, "_fcs_n"},  FCS_n,  1);
    check({pfx, "_ds_n"},   DS_n,   4'hF);
    check({pfx, "_read"},   READ,   0);
    check({pfx, "_adoe"},   ADOE,   0);
    check({pfx, "_doe"},    DOE,    0);
    check({pfx, "_dlatch"}, DLATCH, 0);
    check({pfx, "_sta_n"},  STA_n,  1);
    check({pfx, "_stea_n"}, STEA_n, 1);
  endtask

  // Acknowledge monitor: counts WAIT cycles and compares each termination.
  always @(negedge clk) begin
    if (IORST_n && !(STA_n && STEA_n)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {30'd0, STA_n, STEA_n}, 32'd3);
      end else begin
        mon_e = sb_q.pop_front();
        check("term_sta_n",  STA_n,  mon_e.sta_n);
        check("term_stea_n", STEA_n, mon_e.stea_n);
        check("term_dlatch", DLATCH, mon_e.dlatch);
        check("term_ds_n",   DS_n,   mon_e.ds_n);
        check("term_read",   READ,   mon_e.read);
        check("term_waits",  waits_seen, mon_e.waits);
      end
      waits_seen = 0;
    end else if (IORST_n && DOE && !FCS_n) begin
      waits_seen++;
    end else if (!ADOE) begin
      waits_seen = 0;
    end
  end

  // One SCSI-chip cycle. dly<0: DTACK_n low from the start (ignored until WAIT);
  // berr: BERR_n and DTACK_n together; tmo: no slave response at all.
  task automatic xfer(input logic srw, input logic [1:0] ssiz, input logic [1:0] sa,
                      input int dly, input bit berr, input bit tmo);
    exp_t e;
    int   n;
    bit   err;
    err      = berr || tmo;
    e.ds_n   = exp_lanes(ssiz, sa);
    e.read   = srw;
    e.sta_n  = err;
    e.stea_n = !err;
    e.dlatch = !err && srw;
    e.waits  = tmo ? 255 : ((dly < 0) ? 1 : dly + 1);
    sb_q.push_back(e);

    SRW = srw; SSIZ = ssiz; SA = sa; SAS_n = 1'b0;
    if (dly < 0) DTACK_n = 1'b0;
    tick;
    check("addr_fcs_n", FCS_n, 1);
    check("addr_adoe",  ADOE,  1);
    check("addr_read",  READ,  srw);
    // Request attributes must already be latched.
    SRW = ~srw; SSIZ = ~ssiz; SA = ~sa;
    tick;
    check("strobe_fcs_n", FCS_n, 0);
    n = 0;
    while (!DOE && n < 8) begin
      tick;
      n++;
    end
    check("wait_doe",  DOE,  1);
    check("wait_ds_n", DS_n, e.ds_n);
    check("wait_read", READ, srw);
    if (!tmo && dly >= 0) begin
      repeat (dly) tick;
      DTACK_n = 1'b0;
      if (berr) BERR_n = 1'b0;
    end
    n = 0;
    while (STA_n && STEA_n && n < 300) begin
      tick;
      n++;
    end
    check("term_seen", {31'd0, !(STA_n && STEA_n)}, 1);
    tick;
    check("rel_fcs_n",  FCS_n,  1);
    check("rel_ds_n",   DS_n,   4'hF);
    check("rel_doe",    DOE,    0);
    check("rel_sta_n",  STA_n,  1);
    check("rel_stea_n", STEA_n, 1);
    check("rel_adoe",   ADOE,   1);
    tick;
    check("rel_sas_hold", ADOE, 1);
    SAS_n = 1'b1;
    tick;
    check("rel_dtack_hold", ADOE, {31'd0, !DTACK_n});
    DTACK_n = 1'b1; BERR_n = 1'b1;
    tick;
    check("idle_adoe", ADOE, 0);
    check("idle_read", READ, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    IORST_n = 1'b0; mybus = 1'b1; SAS_n = 1'b1; SRW = 1'b0;
    SSIZ = 2'b00; SA = 2'b00; DTACK_n = 1'b1; BERR_n = 1'b1;
    repeat (3) tick;
    check_reset("rst");
    IORST_n = 1'b1;
    tick;
    check("idle_adoe_pre", ADOE, 0);

    xfer(1'b1, 2'b00, 2'b00, 3, 1'b0, 1'b0);   // long read
    xfer(1'b0, 2'b01, 2'b10, 1, 1'b0, 1'b0);   // byte write
    xfer(1'b1, 2'b10, 2'b10, 0, 1'b0, 1'b0);   // word read, upper half
    xfer(1'b0, 2'b10, 2'b00, 2, 1'b0, 1'b0);   // word write, lower half
    xfer(1'b1, 2'b11, 2'b01, 2, 1'b0, 1'b0);   // line treated as long
    for (int i = 0; i < 4; i++) begin
      xfer(1'(i % 2), 2'b01, 2'(i), int'($urandom_range(0, 4)), 1'b0, 1'b0);
    end
    xfer(1'b1, 2'b00, 2'b00, -1, 1'b0, 1'b0);  // DTACK_n early, ignored before WAIT
    xfer(1'b1, 2'b00, 2'b00, 2, 1'b1, 1'b0);   // BERR_n and DTACK_n together
    xfer(1'b0, 2'b10, 2'b00, 0, 1'b0, 1'b1);   // timeout

    // Bus ownership lost in STROBE.
    begin
      exp_t e;
      e.sta_n = 1'b1; e.stea_n = 1'b0; e.dlatch = 1'b0;
      e.ds_n = 4'hF; e.read = 1'b1; e.waits = 0;
      sb_q.push_back(e);
      SRW = 1'b1; SSIZ = 2'b00; SA = 2'b00; SAS_n = 1'b0;
      tick;
      tick;
      check("drop_strobe_fcs_n", FCS_n, 0);
      mybus = 1'b0;
      tick;
      check("drop_term_stea_n", STEA_n, 0);
      mybus = 1'b1;
      tick;
      check("drop_rel_fcs_n", FCS_n, 1);
      check("drop_rel_adoe",  ADOE,  1);
      SAS_n = 1'b1;
      tick;
      check("drop_idle_adoe", ADOE, 0);
    end

    // Reset in the middle of WAIT.
    SRW = 1'b1; SSIZ = 2'b00; SA = 2'b00; SAS_n = 1'b0;
    tick;
    tick;
    tick;
    check("rstmid_doe", DOE, 1);
    IORST_n = 1'b0;
    tick;
    check_reset("rstmid");
    IORST_n = 1'b1; SAS_n = 1'b1;
    tick;
    xfer(1'b1, 2'b01, 2'b11, 1, 1'b0, 1'b0);   // normal cycle after reset

    tick;
    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
